move_sequencer: RTL and testbench

Single-axis motion command sequencer for the stepper FPGA. Accepts move commands (direction, step count, step period) over a valid/ready handshake and buffers one command behind the active move. It enforces direction setup time before the first step and emits exactly the commanded number of fixed-width step pulses. It reports completion and supports abort. One instance per axis sits between the host command decoder and the axis step/dir pins; it replaces the free-running step pulse generator on those pins.

---
 rtl/qs_pkg.sv | 15 +
 rtl/step_pulse_timer.sv | 37 +++
 rtl/move_sequencer.sv | 155 +++++++++++++++
 tb/tb_move_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qs_pkg.sv
// Shared definitions for the axis motion blocks: sequencer state encoding
// and default step pulse / direction setup timing.
package qs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } qs_state_e;

    localparam int unsigned QS_PULSE_TICKS     = 160;
    localparam int unsigned QS_DIR_SETUP_TICKS = 20;

endpackage

// File: rtl/step_pulse_timer.sv
// Loadable one-shot: i_load starts a WIDTH-cycle high pulse on o_step.
// o_idle is high once the pulse has fully completed.
module step_pulse_timer #(
    parameter int unsigned WIDTH = 160
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_step,
    output logic o_idle
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] r_count;
    logic          r_step;

    // r_step tracks (r_count != 0) one cycle early so the pin is a flop output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_step  <= 1'b0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
            r_step  <= 1'b1;
        end else if (r_count != '0) begin
            r_count <= r_count - ONE;
            r_step  <= (r_count > ONE);
        end
    end

    assign o_step = r_step;
    assign o_idle = (r_count == '0);

endmodule

// File: rtl/move_sequencer.sv
// Single-axis move sequencer: one pending command behind the active move,
// direction setup before the first step, fixed-width step pulses, abort.
module move_sequencer
    import qs_pkg::*;
#(
    parameter int unsigned PERIOD_BITS     = 32,
    parameter int unsigned COUNT_BITS      = 24,
    parameter int unsigned PULSE_TICKS     = QS_PULSE_TICKS,
    parameter int unsigned DIR_SETUP_TICKS = QS_DIR_SETUP_TICKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [COUNT_BITS-1:0]  cmd_steps,
    input  logic [PERIOD_BITS-1:0] cmd_period,
    input  logic                   abort,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [COUNT_BITS-1:0]  steps_left
);

    localparam logic [PERIOD_BITS-1:0] MIN_PERIOD = PERIOD_BITS'(2 * PULSE_TICKS);
    localparam logic [PERIOD_BITS-1:0] SETUP_LAST = PERIOD_BITS'(DIR_SETUP_TICKS - 1);
    localparam logic [PERIOD_BITS-1:0] P_ONE      = PERIOD_BITS'(1);
    localparam logic [COUNT_BITS-1:0]  C_ONE      = COUNT_BITS'(1);

    qs_state_e               r_state;
    logic                    r_pend_full;
    logic                    r_pend_dir;
    logic [COUNT_BITS-1:0]   r_pend_steps;
    logic [PERIOD_BITS-1:0]  r_pend_period;
    logic [PERIOD_BITS-1:0]  r_period;
    logic [PERIOD_BITS-1:0]  r_tick;
    logic [COUNT_BITS-1:0]   r_steps_left;
    logic                    r_dir;
    logic                    r_aborted;

    logic                    w_accept;
    logic                    w_fire;
    logic                    w_timer_idle;
    logic [PERIOD_BITS-1:0]  w_load_period;
    logic                    w_zero_done;
    logic                    w_drain_done;

    assign cmd_ready     = !r_pend_full && !abort;
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_load_period = (r_pend_period < MIN_PERIOD) ? MIN_PERIOD : r_pend_period;
    assign w_fire        = (r_state == ST_RUN) && !abort && (r_tick == r_period - P_ONE);

    // done is decoded from state so a zero-step load and the drain end report
    // in the same cycle they occur rather than one cycle later
    assign w_zero_done  = (r_state == ST_IDLE) && r_pend_full && !abort && (r_pend_steps == '0);
    assign w_drain_done = (r_state == ST_DRAIN) && w_timer_idle;
    assign done         = w_zero_done || w_drain_done;
    assign aborted      = w_drain_done && (r_aborted || abort);
    assign busy         = (r_state != ST_IDLE) || r_pend_full;
    assign dir          = r_dir;
    assign steps_left   = r_steps_left;

    step_pulse_timer #(
        .WIDTH (PULSE_TICKS)
    ) u_pulse (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_fire),
        .o_step (step),
        .o_idle (w_timer_idle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pend_full   <= 1'b0;
            r_pend_dir    <= 1'b0;
            r_pend_steps  <= '0;
            r_pend_period <= '0;
            r_period      <= '0;
            r_tick        <= '0;
            r_steps_left  <= '0;
            r_dir         <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_full   <= 1'b1;
                r_pend_dir    <= cmd_dir;
                r_pend_steps  <= cmd_steps;
                r_pend_period <= cmd_period;
            end
            case (r_state)
                ST_IDLE: begin
                    if (abort) begin
                        r_pend_full <= 1'b0;
                    end else if (r_pend_full) begin
                        r_pend_full  <= 1'b0;
                        r_steps_left <= r_pend_steps;
                        r_period     <= w_load_period;
                        r_tick       <= '0;
                        r_aborted    <= 1'b0;
                        if (r_pend_steps != '0) begin
                            if (r_pend_dir != r_dir) begin
                                r_dir   <= r_pend_dir;
                                r_state <= ST_SETUP;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        r_pend_full <= 1'b0;
                        r_aborted   <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else if (r_tick == SETUP_LAST) begin
                        r_tick  <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_tick <= r_tick + P_ONE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_pend_full <= 1'b0;
                        r_aborted   <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else if (w_fire) begin
                        r_tick       <= '0;
                        r_steps_left <= r_steps_left - C_ONE;
                        if (r_steps_left == C_ONE) begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_tick <= r_tick + P_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_pend_full <= 1'b0;
                        r_aborted   <= 1'b1;
                    end
                    if (w_timer_idle) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: expected step rises and done events
// are queued per command and consumed by a negedge monitor.
module tb_move_sequencer;

    localparam int PB = 32;
    localparam int CB = 24;
    localparam int PULSE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [CB-1:0] cmd_steps = '0;
    logic [PB-1:0] cmd_period = '0;
    logic          abort = 1'b0;
    logic          cmd_ready, step, dir, busy, done, aborted;
    logic [CB-1:0] steps_left;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 0;
    logic prev_step = 1'b0;
    int rise_cyc = 0;
    int mon_exp;

    typedef struct {
        int   c;
        logic ab;
        int   sl;
    } done_t;

    int    q_rise[$];
    done_t q_done[$];
    done_t mon_d;

    move_sequencer #(
        .PERIOD_BITS     (PB),
        .COUNT_BITS      (CB),
        .PULSE_TICKS     (PULSE),
        .DIR_SETUP_TICKS (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (step && !prev_step) begin
                n_checks++;
                if (q_rise.size() == 0) begin
                    n_fail++;
                    $display("FAIL step_rise unexpected at cyc=%0d", cyc);
                end else begin
                    mon_exp = q_rise.pop_front();
                    if (cyc !== mon_exp) begin
                        n_fail++;
                        $display("FAIL step_rise got cyc=%0d expected cyc=%0d", cyc, mon_exp);
                    end
                end
                rise_cyc = cyc;
            end
            if (!step && prev_step) begin
                n_checks++;
                if (cyc - rise_cyc !== PULSE) begin
                    n_fail++;
                    $display("FAIL step_width got=%0d expected=%0d", cyc - rise_cyc, PULSE);
                end
            end
            if (done) begin
                n_checks++;
                if (q_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL done unexpected at cyc=%0d", cyc);
                end else begin
                    mon_d = q_done.pop_front();
                    if (cyc !== mon_d.c || aborted !== mon_d.ab || int'(steps_left) !== mon_d.sl) begin
                        n_fail++;
                        $display("FAIL done_event got cyc=%0d aborted=%b steps_left=%0d expected cyc=%0d aborted=%b steps_left=%0d",
                                 cyc, aborted, steps_left, mon_d.c, mon_d.ab, mon_d.sl);
                    end
                end
            end
        end
        prev_step = step;
    end

    task automatic issue_cmd(input logic d, input int s, input int p, output int c0);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = CB'(s);
        cmd_period = PB'(p);
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_accept timeout got ready=%b expected ready=1", cmd_ready);
        end
        c0 = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_to(input int c0, input int n);
        do @(negedge clk); while (cyc - c0 < n);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_timeout got busy=%b expected busy=0", name, busy);
        end
        n_checks++;
        if (q_rise.size() != 0 || q_done.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_events got rise_left=%0d done_left=%0d expected 0 and 0",
                     name, q_rise.size(), q_done.size());
        end
    endtask

    task automatic test_reset();
        int c0;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        n_checks++;
        if ({step, dir, busy, done, aborted} !== 5'b0 || steps_left !== '0) begin
            n_fail++;
            $display("FAIL reset_state got step,dir,busy,done,aborted=%b steps_left=%0d expected 00000 and 0",
                     {step, dir, busy, done, aborted}, steps_left);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got=%b expected=1", cmd_ready);
        end
        issue_cmd(1'b1, 3, 10, c0);
        for (int i = 0; i < 40 && !step; i++) @(negedge clk);
        n_checks++;
        if (step !== 1'b1 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prepulse got step=%b dir=%b expected step=1 dir=1", step, dir);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({step, dir, busy, done, aborted} !== 5'b0 || steps_left !== '0) begin
            n_fail++;
            $display("FAIL reset_midpulse got step,dir,busy,done,aborted=%b steps_left=%0d expected 00000 and 0",
                     {step, dir, busy, done, aborted}, steps_left);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy);
        end
        q_rise.delete();
        q_done.delete();
        prev_step = 1'b0;
        mon_en = 1;
    endtask

    task automatic test_basic();
        int c0;
        @(negedge clk);
        issue_cmd(1'b0, 3, 10, c0);
        q_rise.push_back(c0 + 12);
        q_rise.push_back(c0 + 22);
        q_rise.push_back(c0 + 32);
        q_done.push_back('{c: c0 + 36, ab: 1'b0, sl: 0});
        wait_to(c0, 2);
        n_checks++;
        if (steps_left !== CB'(3) || dir !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_load got steps_left=%0d dir=%b busy=%b expected 3 0 1", steps_left, dir, busy);
        end
        wait_to(c0, 13);
        n_checks++;
        if (steps_left !== CB'(2)) begin
            n_fail++;
            $display("FAIL basic_count got steps_left=%0d expected=2", steps_left);
        end
        wait_idle("basic");
    endtask

    task automatic test_dir_change();
        int c0;
        issue_cmd(1'b1, 1, 10, c0);
        q_rise.push_back(c0 + 15);
        q_done.push_back('{c: c0 + 19, ab: 1'b0, sl: 0});
        wait_to(c0, 1);
        n_checks++;
        if (dir !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_before got=%b expected=0", dir);
        end
        wait_to(c0, 2);
        n_checks++;
        if (dir !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_after got=%b expected=1", dir);
        end
        wait_idle("dir_change");
    endtask

    task automatic test_zero_steps();
        int c0;
        issue_cmd(1'b0, 0, 10, c0);
        q_done.push_back('{c: c0 + 1, ab: 1'b0, sl: 0});
        wait_to(c0, 3);
        n_checks++;
        if (dir !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_steps got dir=%b busy=%b expected dir=1 busy=0", dir, busy);
        end
        wait_idle("zero_steps");
    endtask

    task automatic test_clamp();
        int c0;
        issue_cmd(1'b1, 2, 3, c0);
        q_rise.push_back(c0 + 10);
        q_rise.push_back(c0 + 18);
        q_done.push_back('{c: c0 + 22, ab: 1'b0, sl: 0});
        wait_to(c0, 2);
        wait_idle("clamp");
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        issue_cmd(1'b1, 2, 10, c0);
        q_rise.push_back(c0 + 12);
        q_rise.push_back(c0 + 22);
        q_done.push_back('{c: c0 + 26, ab: 1'b0, sl: 0});
        wait_to(c0, 1);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_pending got=%b expected=0", cmd_ready);
        end
        wait_to(c0, 5);
        issue_cmd(1'b1, 1, 12, c1);
        q_rise.push_back(c0 + 40);
        q_done.push_back('{c: c0 + 44, ab: 1'b0, sl: 0});
        wait_to(c0, 10);
        n_checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_held got ready=%b busy=%b expected ready=0 busy=1", cmd_ready, busy);
        end
        wait_to(c0, 27);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_before_load got ready=%b expected=0", cmd_ready);
        end
        wait_to(c0, 28);
        n_checks++;
        if (cmd_ready !== 1'b1 || steps_left !== CB'(1)) begin
            n_fail++;
            $display("FAIL b2b_after_load got ready=%b steps_left=%0d expected ready=1 steps_left=1",
                     cmd_ready, steps_left);
        end
        wait_idle("back_to_back");
    endtask

    task automatic test_abort();
        int c0;
        int c1;
        issue_cmd(1'b1, 3, 10, c0);
        q_rise.push_back(c0 + 12);
        q_done.push_back('{c: c0 + 16, ab: 1'b1, sl: 2});
        wait_to(c0, 5);
        issue_cmd(1'b0, 5, 10, c1);
        wait_to(c0, 13);
        abort = 1'b1;
        wait_to(c0, 14);
        abort = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || steps_left !== CB'(2)) begin
            n_fail++;
            $display("FAIL abort_flush got ready=%b steps_left=%0d expected ready=1 steps_left=2",
                     cmd_ready, steps_left);
        end
        wait_to(c0, 17);
        n_checks++;
        if (busy !== 1'b0 || dir !== 1'b1 || steps_left !== CB'(2)) begin
            n_fail++;
            $display("FAIL abort_after got busy=%b dir=%b steps_left=%0d expected busy=0 dir=1 steps_left=2",
                     busy, dir, steps_left);
        end
        wait_to(c0, 50);
        wait_idle("abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dir_change();
        test_zero_steps();
        test_clamp();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
